// File: rtl/wr_512b_to_bram_pkg.sv
// Shared row-BRAM geometry, handshake constants and FSM state type for the 512b row writer.
package wr_512b_to_bram_pkg;

  localparam int ROW_W         = 9;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_ROW = 16;
  localparam int ADDR_W        = 13;
  localparam int CNT_W         = ADDR_W - ROW_W;
  localparam int ROW_BITS      = WORD_W * WORDS_PER_ROW;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_WR_REQ,
    ST_WR_REL,
    ST_DONE
  } wr_state_e;

  // Word address is a pure concatenation, so the last word of row 511 lands on 13'h1FFF.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_W-1:0] row,
                                                  input logic [CNT_W-1:0] word);
    return {row, word};
  endfunction

endpackage

// File: rtl/wr_512b_to_bram.sv
// Serialises one 512b row into 16 word writes over the trig/done BRAM controller bus; optional per-word mask via WR512_WORD_MASK_EN.
// Latency: 2 cycles IDLE/SEL + per enabled word (1 SEL + handshake) + 1 DONE; client trig/done and BRAM trig/done are 4-phase, so both sides stall freely.
module wr_512b_to_bram
  import wr_512b_to_bram_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_trig,
  output logic                o_done,
  input  logic [ROW_W-1:0]    i_wr_row_num,
  input  logic [ROW_BITS-1:0] i_wr_data_512b,
`ifdef WR512_WORD_MASK_EN
  input  logic [WORDS_PER_ROW-1:0] i_wr_word_mask,
`endif
  output logic [ADDR_W-1:0]   o_wr_to_bram_addr,
  output logic [WORD_W-1:0]   o_wr_to_bram_data,
  output logic                o_wr_to_bram_trig,
  input  logic                i_wr_to_bram_done
);

  wr_state_e state, state_nxt;

  logic [CNT_W-1:0]         word_cnt;
  logic [ROW_BITS-1:0]      sreg;
  logic [ROW_W-1:0]         row_q;
  logic [WORDS_PER_ROW-1:0] word_mask;
  logic                     done_pre;

  logic do_load, do_issue, do_release, do_adv, set_done, clr_done;

`ifdef WR512_WORD_MASK_EN
  logic [WORDS_PER_ROW-1:0] mask_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      mask_q <= '0;
    else if (do_load)
      mask_q <= i_wr_word_mask;
  end

  assign word_mask = mask_q;
`else
  assign word_mask = '1;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_issue   = 1'b0;
    do_release = 1'b0;
    do_adv     = 1'b0;
    set_done   = 1'b0;
    clr_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_trig) begin
          do_load   = 1'b1;
          state_nxt = ST_SEL;
        end
      end
      ST_SEL: begin
        if (word_mask[word_cnt]) begin
          do_issue  = 1'b1;
          state_nxt = ST_WR_REQ;
        end else if (word_cnt == LAST_WORD) begin
          state_nxt = ST_DONE;
        end else begin
          do_adv = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (i_wr_to_bram_done) begin
          do_release = 1'b1;
          state_nxt  = ST_WR_REL;
        end
      end
      ST_WR_REL: begin
        if (!i_wr_to_bram_done) begin
          if (word_cnt == LAST_WORD) begin
            state_nxt = ST_DONE;
          end else begin
            do_adv    = 1'b1;
            state_nxt = ST_SEL;
          end
        end
      end
      ST_DONE: begin
        // Client may have dropped trig mid-row; in that case leave without ever showing done.
        if (!i_trig) begin
          clr_done  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          set_done = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      word_cnt          <= '0;
      sreg              <= '0;
      row_q             <= '0;
      o_wr_to_bram_addr <= '0;
      o_wr_to_bram_data <= '0;
      o_wr_to_bram_trig <= 1'b0;
      done_pre          <= 1'b0;
    end else begin
      if (do_load) begin
        row_q    <= i_wr_row_num;
        sreg     <= i_wr_data_512b;
        word_cnt <= '0;
      end
      if (do_adv) begin
        word_cnt <= word_cnt + CNT_W'(1);
        sreg     <= sreg >> WORD_W;
      end
      if (do_issue) begin
        o_wr_to_bram_addr <= word_addr(row_q, word_cnt);
        o_wr_to_bram_data <= sreg[WORD_W-1:0];
        o_wr_to_bram_trig <= 1'b1;
      end
      if (do_release)
        o_wr_to_bram_trig <= 1'b0;
      if (set_done)
        done_pre <= 1'b1;
      else if (clr_done)
        done_pre <= 1'b0;
    end
  end

  assign o_done = done_pre & i_trig;

endmodule

// File: tb/tb_wr_512b_to_bram.sv
// Directed bench for wr_512b_to_bram with a trig/done BRAM controller responder model.
module tb_wr_512b_to_bram;

  logic         clk;
  logic         rstn;
  logic         trig;
  logic         done;
  logic [8:0]   row_num;
  logic [511:0] payload;
`ifdef WR512_WORD_MASK_EN
  logic [15:0]  mask;
`endif
  logic [12:0]  addr;
  logic [31:0]  wdata;
  logic         btrig;
  logic         bdone;

  int n_checks = 0;
  int n_fail   = 0;

  int ack_dly  = 2;
  int rel_dly  = 1;
  int ack_cnt  = 0;
  int stab_err = 0;
  int ovl_err  = 0;
  logic [12:0] wa[$];
  logic [31:0] wd[$];

  wr_512b_to_bram dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_trig            (trig),
    .o_done            (done),
    .i_wr_row_num      (row_num),
    .i_wr_data_512b    (payload),
`ifdef WR512_WORD_MASK_EN
    .i_wr_word_mask    (mask),
`endif
    .o_wr_to_bram_addr (addr),
    .o_wr_to_bram_data (wdata),
    .o_wr_to_bram_trig (btrig),
    .i_wr_to_bram_done (bdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM write-controller model: logs each request, acks after ack_dly, holds done rel_dly after trig falls.
  initial begin
    bdone = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (btrig === 1'b1 && bdone === 1'b0 && rstn === 1'b1) begin
        wa.push_back(addr);
        wd.push_back(wdata);
        for (int i = 1; i < ack_dly; i++) begin
          @(posedge clk); #1;
          if (btrig === 1'b1 && (addr !== wa[$] || wdata !== wd[$])) stab_err++;
        end
        bdone = 1'b1;
        ack_cnt++;
        for (int i = 0; i < 200 && btrig === 1'b1; i++) begin
          @(posedge clk); #1;
        end
        for (int i = 1; i < rel_dly; i++) begin
          @(posedge clk); #1;
          if (btrig === 1'b1) ovl_err++;
        end
        bdone = 1'b0;
      end
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ack_cnt  = 0;
    stab_err = 0;
    ovl_err  = 0;
  endtask

  task automatic wait_row_done(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    trig    = 1'b0;
    row_num = '0;
    payload = '0;
`ifdef WR512_WORD_MASK_EN
    mask    = 16'hFFFF;
`endif
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (btrig !== 1'b0) begin n_fail++; $display("FAIL reset_trig got=%b exp=0", btrig); end
    n_checks++; if (addr !== 13'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr); end
    n_checks++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", wdata); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (btrig !== 1'b0) begin n_fail++; $display("FAIL idle_trig got=%b exp=0", btrig); end
  endtask

  task automatic test_row5();
    bit got;
    clear_log();
    ack_dly = 2;
    rel_dly = 1;
    row_num = 9'd5;
    for (int k = 0; k < 16; k++) payload[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    trig = 1'b1;
    repeat (3) @(negedge clk);
    row_num = 9'h1AA;
    payload = {16{32'hDEAD_BEEF}};
    wait_row_done(500, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL row5_done got=%b exp=1", got); end
    trig = 1'b0;
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL row5_done_gate got=%b exp=0", done); end
    n_checks++; if (wa.size() !== 16) begin n_fail++; $display("FAIL row5_count got=%0d exp=16", wa.size()); end
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      n_checks++; if (wa[k] !== 13'h050 + 13'(k)) begin n_fail++; $display("FAIL row5_addr[%0d] got=%h exp=%h", k, wa[k], 13'h050 + 13'(k)); end
      n_checks++; if (wd[k] !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL row5_data[%0d] got=%h exp=%h", k, wd[k], 32'hA000_0000 + 32'(k)); end
    end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL row5_stable got=%0d exp=0", stab_err); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_row511();
    bit got;
    clear_log();
    row_num = 9'd511;
    payload = '1;
    trig = 1'b1;
    wait_row_done(500, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL row511_done got=%b exp=1", got); end
    trig = 1'b0;
    n_checks++; if (wa.size() !== 16) begin n_fail++; $display("FAIL row511_count got=%0d exp=16", wa.size()); end
    if (wa.size() == 16) begin
      n_checks++; if (wa[0] !== 13'h1FF0) begin n_fail++; $display("FAIL row511_first_addr got=%h exp=1ff0", wa[0]); end
      n_checks++; if (wa[15] !== 13'h1FFF) begin n_fail++; $display("FAIL row511_last_addr got=%h exp=1fff", wa[15]); end
      n_checks++; if (wd[15] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL row511_last_data got=%h exp=ffffffff", wd[15]); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_trig_drop();
    bit got;
    bit seen_done;
    bit reached;
    clear_log();
    row_num = 9'd7;
    for (int k = 0; k < 16; k++) payload[k*32 +: 32] = 32'h7700_0000 + 32'(k);
    trig = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack_cnt >= 3) begin reached = 1'b1; break; end
    end
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL drop_third_ack got=%0d exp=3", ack_cnt); end
    trig = 1'b0;
    seen_done = 1'b0;
    reached   = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
      if (ack_cnt == 16 && bdone === 1'b0) begin reached = 1'b1; break; end
    end
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL drop_finish got=%0d acks exp=16", ack_cnt); end
    n_checks++; if (wa.size() !== 16) begin n_fail++; $display("FAIL drop_count got=%0d exp=16", wa.size()); end
    if (wa.size() == 16) begin
      n_checks++; if (wa[15] !== 13'h07F || wd[15] !== 32'h7700_000F) begin n_fail++; $display("FAIL drop_last got=%h/%h exp=07f/7700000f", wa[15], wd[15]); end
    end
    @(negedge clk);
    if (done === 1'b1) seen_done = 1'b1;
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL drop_no_done got=%b exp=0", seen_done); end
    // FSM is back in IDLE one cycle after DONE: a new request issues its first word two cycles later.
    @(negedge clk);
    row_num = 9'd9;
    payload = {16{32'h0909_0909}};
    trig = 1'b1;
    @(negedge clk);
    n_checks++; if (btrig !== 1'b0) begin n_fail++; $display("FAIL restart_early got=%b exp=0", btrig); end
    @(negedge clk);
    n_checks++; if (btrig !== 1'b1) begin n_fail++; $display("FAIL restart_trig got=%b exp=1", btrig); end
    n_checks++; if (addr !== 13'h090) begin n_fail++; $display("FAIL restart_addr got=%h exp=090", addr); end
    wait_row_done(500, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL restart_done got=%b exp=1", got); end
    trig = 1'b0;
    n_checks++; if (wa.size() !== 32) begin n_fail++; $display("FAIL restart_count got=%0d exp=32", wa.size()); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit got;
    clear_log();
    ack_dly = 1;
    rel_dly = 5;
    row_num = 9'd3;
    for (int k = 0; k < 16; k++) payload[k*32 +: 32] = 32'h3300_0000 + 32'(k * 3);
    trig = 1'b1;
    wait_row_done(1000, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", got); end
    trig = 1'b0;
    n_checks++; if (wa.size() !== 16) begin n_fail++; $display("FAIL b2b_count got=%0d exp=16", wa.size()); end
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      n_checks++; if (wa[k] !== 13'h030 + 13'(k) || wd[k] !== 32'h3300_0000 + 32'(k * 3)) begin n_fail++; $display("FAIL b2b_word[%0d] got=%h/%h exp=%h/%h", k, wa[k], wd[k], 13'h030 + 13'(k), 32'h3300_0000 + 32'(k * 3)); end
    end
    n_checks++; if (ovl_err !== 0) begin n_fail++; $display("FAIL b2b_trig_while_done got=%0d exp=0", ovl_err); end
    ack_dly = 2;
    rel_dly = 1;
    repeat (8) @(negedge clk);
  endtask

`ifdef WR512_WORD_MASK_EN
  task automatic test_word_mask();
    bit got;
    clear_log();
    row_num = 9'd2;
    for (int k = 0; k < 16; k++) payload[k*32 +: 32] = 32'h2200_0000 + 32'(k);
    mask = 16'h8001;
    trig = 1'b1;
    wait_row_done(500, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL mask8001_done got=%b exp=1", got); end
    trig = 1'b0;
    n_checks++; if (wa.size() !== 2) begin n_fail++; $display("FAIL mask8001_count got=%0d exp=2", wa.size()); end
    if (wa.size() == 2) begin
      n_checks++; if (wa[0] !== 13'h020 || wd[0] !== 32'h2200_0000) begin n_fail++; $display("FAIL mask8001_w0 got=%h/%h exp=020/22000000", wa[0], wd[0]); end
      n_checks++; if (wa[1] !== 13'h02F || wd[1] !== 32'h2200_000F) begin n_fail++; $display("FAIL mask8001_w15 got=%h/%h exp=02f/2200000f", wa[1], wd[1]); end
    end
    repeat (4) @(negedge clk);
    clear_log();
    mask = 16'h0000;
    trig = 1'b1;
    wait_row_done(100, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL mask0_done got=%b exp=1", got); end
    trig = 1'b0;
    n_checks++; if (wa.size() !== 0) begin n_fail++; $display("FAIL mask0_count got=%0d exp=0", wa.size()); end
    mask = 16'hFFFF;
    repeat (4) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_write();
    bit reached;
    bit spurious;
    clear_log();
    ack_dly = 20;
    row_num = 9'd4;
    payload = '0;
    payload[31:0] = 32'h1234_5678;
    trig = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (btrig === 1'b1) begin reached = 1'b1; break; end
    end
    n_checks++; if (reached !== 1'b1 || addr !== 13'h040) begin n_fail++; $display("FAIL midrst_req got=%b/%h exp=1/040", btrig, addr); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (btrig !== 1'b0) begin n_fail++; $display("FAIL midrst_trig got=%b exp=0", btrig); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
    n_checks++; if (addr !== 13'h0) begin n_fail++; $display("FAIL midrst_addr got=%h exp=0", addr); end
    n_checks++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_data got=%h exp=0", wdata); end
    trig = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (btrig !== 1'b0 || done !== 1'b0) spurious = 1'b1;
    end
    n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got=%b exp=0", spurious); end
    ack_dly = 2;
  endtask

  initial begin
    test_reset();
    test_row5();
    test_row511();
    test_trig_drop();
    test_back_to_back();
`ifdef WR512_WORD_MASK_EN
    test_word_mask();
`endif
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
